// File: rtl/modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : modexp_ctrl
// Brief    : Left-to-right square-and-multiply sequencer, base^exp mod 2^94-3,
//            driving an external modular multiplier of configurable latency.
// Revision : 1.0
// ============================================================================
module modexp_ctrl #(
    parameter int EXP_W   = 94,
    parameter int MUL_LAT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [93:0]      base,
    input  logic [EXP_W-1:0] exp,
    output logic             busy,
    output logic             done,
    output logic [93:0]      result,
    output logic [93:0]      mul_a,
    output logic [93:0]      mul_b,
    input  logic [93:0]      mul_m
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam int CNT_W = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

    localparam logic [93:0]      c_p        = {{92{1'b1}}, 2'b01};
    localparam logic [IDX_W-1:0] c_idx_top  = IDX_W'(EXP_W - 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MUL_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SQR  = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [93:0]      r_acc;
    logic [93:0]      r_base;
    logic [EXP_W-1:0] r_exp;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             w_op_last;
    logic             w_idx_zero;
    logic [93:0]      w_base_red;

    // Any 94-bit input is below 2P, so one conditional subtract fully reduces it.
    assign w_base_red = (base >= c_p) ? (base - c_p) : base;
    assign w_op_last  = (r_cnt == c_cnt_last);
    assign w_idx_zero = (r_idx == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        mul_a       = '0;
        mul_b       = '0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_SQR;
                end
            end
            S_SQR: begin
                mul_a = r_acc;
                mul_b = r_acc;
                if (w_op_last) begin
                    if (r_exp[r_idx]) begin
                        w_state_nxt = S_MUL;
                    end else if (w_idx_zero) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_MUL: begin
                mul_a = r_acc;
                mul_b = r_base;
                if (w_op_last) begin
                    w_state_nxt = w_idx_zero ? S_DONE : S_SQR;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: accumulator and index only move on the last cycle of an op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc  <= 94'd1;
            r_base <= '0;
            r_exp  <= '0;
            r_idx  <= c_idx_top;
            r_cnt  <= '0;
            result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (start) begin
                        r_exp  <= exp;
                        r_base <= w_base_red;
                        r_acc  <= 94'd1;
                        r_idx  <= c_idx_top;
                    end
                end
                S_SQR: begin
                    if (w_op_last) begin
                        r_acc <= mul_m;
                        r_cnt <= '0;
                        if (!r_exp[r_idx] && !w_idx_zero) begin
                            r_idx <= r_idx - 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_MUL: begin
                    if (w_op_last) begin
                        r_acc <= mul_m;
                        r_cnt <= '0;
                        if (!w_idx_zero) begin
                            r_idx <= r_idx - 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    result <= r_acc;
                    r_cnt  <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
- Sequencer for left-to-right square-and-multiply modular exponentiation: result = base^exp mod P, with P = 2^94 - 3.
- Sits directly upstream of the 94-bit modular multiplier: drives its a/b operands and consumes its m product.
- One multiplication is issued at a time. The multiplier's latency is configurable, so both the combinational and the pipelined multiplier variants can be attached.

Parameters:
- EXP_W, 94: exponent width in bits; the number of square steps performed is always EXP_W.
- MUL_LAT, 0: multiplier latency in clock cycles; 0 means combinational, and the product is captured in the same cycle the operands are applied.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- base  input  94  base operand; sampled on the start edge.
- exp  input  EXP_W  exponent; sampled on the start edge.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle, inclusive.
- done  output  1  one-cycle completion pulse.
- result  output  94  final value; held until the next completion.
- mul_a  output  94  multiplier operand a.
- mul_b  output  94  multiplier operand b.
- mul_m  input  94  multiplier product, (mul_a*mul_b) mod P.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy=0, done=0, result=0, mul_a=0, mul_b=0.
  - Internal accumulator acc=1, bit index idx=EXP_W-1, wait counter=0.
  - A reset asserted mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, SQR, MUL, DONE.
- IDLE:
  - On start=1, latch exp and base_r, then go to SQR with acc=1 and idx=EXP_W-1.
  - base_r = base if base < P, otherwise base - P (result in 0..2).
- SQR:
  - Drive mul_a=acc, mul_b=acc.
  - On the final cycle of the op, acc <= mul_m. Then:
    - if exp[idx]=1, go to MUL;
    - else if idx=0, go to DONE;
    - else idx--, stay in SQR.
- MUL:
  - Drive mul_a=acc, mul_b=base_r.
  - On the final cycle, acc <= mul_m. Then, if idx=0, go to DONE; else idx--, go to SQR.
- Op timing:
  - Every SQR/MUL op lasts MUL_LAT+1 cycles, with operands held stable throughout.
  - A wait counter counts 0..MUL_LAT; acc, idx and state advance only when counter=MUL_LAT.
- DONE (single cycle):
  - result <= acc, done=1, busy=1.
  - Next state is IDLE, with busy=0 and done=0.
- mul_a and mul_b are decoded from state and are 0 in IDLE and DONE.
- Latency:
  - With N = (MUL_LAT+1)*(EXP_W + popcount(exp)), done is high in cycle N+1 after the accepting edge.
  - A new start is accepted in the cycle after done.
- start while busy is ignored; no queueing.
- exp=0 gives result 1, including base=0 (0^0 defined as 1).
- All arithmetic is 94-bit. acc always holds a value < P, given a correct multiplier.
- result changes only at DONE.

Test Plan:
- EXP_W=94, MUL_LAT=0, base=2, exp=10 -> done in cycle 97 after start; result=0x400; busy high for cycles 1..97.
- base=0xF0F0F0, exp=1 -> result=0xF0F0F0. Then base=P-1, exp=2 -> result=1. Then base=2^94-1 (=P+2), exp=1 -> result=2.
- exp=0 with base=0 and with base=0x123 -> result=1 in both cases, done in cycle 95.
- MUL_LAT=2, base=3, exp=5 -> result=0xF3; done in cycle 3*(94+2)+1=289; mul_a/mul_b stable across each 3-cycle op.
- start pulsed again at cycle 10 of a running op -> ignored: single done pulse, result unchanged from the single-run value. Reset pulsed at cycle 40 -> busy=0, done=0, result=0 immediately; no done pulse; a fresh start afterwards completes correctly.
- Random base < P, random 94-bit exp, 100 runs against a model using the same multiplier -> every result matches; done is exactly one cycle wide.
